// File: rtl/req_arbiter.sv
// rtl/req_arbiter.sv - four-requester round-robin arbiter with hold-time limit
module req_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] gnt,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout
);

    // Counter only has to reach MAX_HOLD-1 before release, so this width never wraps.
    localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_GRANT   = 2'b01,
        S_RELEASE = 2'b10
    } state_t;

    state_t          r_state;
    logic [3:0]      r_gnt;
    logic [1:0]      r_owner;
    logic            r_busy;
    logic            r_timeout;
    logic [1:0]      r_ptr;
    logic [HW-1:0]   r_hold;

    state_t          w_state_nxt;
    logic [3:0]      w_gnt_nxt;
    logic [1:0]      w_owner_nxt;
    logic            w_busy_nxt;
    logic            w_timeout_nxt;
    logic [1:0]      w_ptr_nxt;
    logic [HW-1:0]   w_hold_nxt;

    logic            w_any;
    logic [1:0]      w_sel;
    logic            w_done_own;
    logic            w_req_own;
    logic            w_expire;
    logic            w_last;

    // Round-robin pick: first set request scanning upward from the pointer.
    always_comb begin
        w_any = 1'b0;
        w_sel = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[r_ptr + 2'(k)]) begin
                w_any = 1'b1;
                w_sel = r_ptr + 2'(k);
            end
        end
    end

    assign w_done_own = done[r_owner];
    assign w_req_own  = req[r_owner];
    assign w_expire   = (r_hold == HOLD_LAST);
    assign w_last     = w_done_own | ~w_req_own | w_expire;

    // Next-state and next-output decode; every register defaults to holding.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_owner_nxt   = r_owner;
        w_busy_nxt    = r_busy;
        w_timeout_nxt = 1'b0;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold;
        case (r_state)
            S_IDLE: begin
                w_gnt_nxt  = 4'b0000;
                w_busy_nxt = 1'b0;
                if (w_any) begin
                    w_gnt_nxt   = 4'b0001 << w_sel;
                    w_owner_nxt = w_sel;
                    w_busy_nxt  = 1'b1;
                    w_hold_nxt  = '0;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (w_last) begin
                    w_gnt_nxt     = 4'b0000;
                    w_busy_nxt    = 1'b0;
                    w_ptr_nxt     = r_owner + 2'd1;
                    // Timeout only flags revocation that the owner did not ask for.
                    w_timeout_nxt = w_expire & ~w_done_own & w_req_own;
                    w_state_nxt   = S_RELEASE;
                end else begin
                    w_hold_nxt = r_hold + HW'(1);
                end
            end
            S_RELEASE: begin
                w_gnt_nxt   = 4'b0000;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_gnt_nxt   = 4'b0000;
                w_owner_nxt = 2'd0;
                w_busy_nxt  = 1'b0;
                w_ptr_nxt   = 2'd0;
                w_hold_nxt  = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; synchronous active-low reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_gnt     <= 4'b0000;
            r_owner   <= 2'd0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_ptr     <= 2'd0;
            r_hold    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_owner   <= w_owner_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
            r_ptr     <= w_ptr_nxt;
            r_hold    <= w_hold_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign owner   = r_owner;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_req_arbiter.sv
// tb/tb_req_arbiter.sv - scoreboard bench for req_arbiter
module tb_req_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;

    logic [3:0] g8, g1;
    logic [1:0] o8, o1;
    logic       b8, b1, t8, t1;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int vec_id = 0;
    logic cur_sel = 1'b0;

    int       q_cyc[$];
    int       q_id[$];
    logic     q_sel[$];
    logic [7:0] q_exp[$];

    always #5 clk = ~clk;

    req_arbiter #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(g8), .owner(o8), .busy(b8), .timeout(t8)
    );

    req_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(g1), .owner(o1), .busy(b1), .timeout(t1)
    );

    // cycle counter shared by driver and monitor
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: pops expectations due this cycle and compares
    always @(negedge clk) begin
        logic [7:0] act;
        logic [7:0] ex;
        int         ec;
        int         id;
        logic       s;
        if (cyc > 0) begin
            n_cmp++;
            if (!$onehot0(g8) || !$onehot0(g1)) begin
                n_fail++;
                $display("FAIL onehot cyc%0d: gnt8=%b gnt1=%b required at most one bit", cyc, g8, g1);
            end
        end
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            ec = q_cyc.pop_front();
            id = q_id.pop_front();
            s  = q_sel.pop_front();
            ex = q_exp.pop_front();
            act = s ? {g1, o1, b1, t1} : {g8, o8, b8, t8};
            n_cmp++;
            if (ec != cyc || act !== ex) begin
                n_fail++;
                $display("FAIL vec%0d (dut%0d cyc%0d): got gnt/owner/busy/timeout=%b_%b_%b_%b required %b_%b_%b_%b",
                         id, s ? 1 : 8, cyc, act[7:4], act[3:2], act[1], act[0],
                         ex[7:4], ex[3:2], ex[1], ex[0]);
            end
        end
    end

    task automatic drv(input logic r, input logic [3:0] rq, input logic [3:0] dn,
                       input logic [3:0] eg, input logic [1:0] eo, input logic eb, input logic et);
        rst  = r;
        req  = rq;
        done = dn;
        q_cyc.push_back(cyc + 1);
        q_id.push_back(vec_id);
        q_sel.push_back(cur_sel);
        q_exp.push_back({eg, eo, eb, et});
        vec_id++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] o;
        rst  = 1'b0;
        req  = 4'b0000;
        done = 4'b0000;
        @(posedge clk);
        #1;
        // reset state
        drv(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
        // single request, done release, ptr moves to 3
        drv(1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0);
        drv(1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0);
        drv(1, 4'b0100, 4'b0100, 4'b0000, 2'd2, 0, 0);
        drv(1, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0, 0);
        drv(1, 4'b1100, 4'b0000, 4'b1000, 2'd3, 1, 0);
        drv(1, 4'b1100, 4'b1000, 4'b0000, 2'd3, 0, 0);
        drv(1, 4'b0000, 4'b0000, 4'b0000, 2'd3, 0, 0);
        drv(1, 4'b0000, 4'b0000, 4'b0000, 2'd3, 0, 0);
        // round robin with all requesting
        for (int k = 0; k < 5; k++) begin
            o = 2'(k % 4);
            drv(1, 4'b1111, 4'b0000, 4'(1) << o, o, 1, 0);
            drv(1, 4'b1111, 4'(1) << o, 4'b0000, o, 0, 0);
            drv(1, 4'b1111, 4'b0000, 4'b0000, o, 0, 0);
        end
        // non-owner done ignored, then req drop releases
        drv(1, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1, 0);
        drv(1, 4'b0010, 4'b1000, 4'b0010, 2'd1, 1, 0);
        drv(1, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1, 0);
        drv(1, 4'b0000, 4'b0000, 4'b0000, 2'd1, 0, 0);
        drv(1, 4'b0000, 4'b0000, 4'b0000, 2'd1, 0, 0);
        // hold expiry: 8 grant cycles then timeout pulse
        drv(1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0);
        for (int k = 0; k < 7; k++) drv(1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0);
        drv(1, 4'b0001, 4'b0000, 4'b0000, 2'd0, 0, 1);
        drv(1, 4'b0001, 4'b0000, 4'b0000, 2'd0, 0, 0);
        drv(1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0);
        // done coinciding with expiry: no timeout
        for (int k = 0; k < 7; k++) drv(1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0);
        drv(1, 4'b0001, 4'b0001, 4'b0000, 2'd0, 0, 0);
        drv(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
        // reset mid-grant with owner 3
        drv(1, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1, 0);
        drv(1, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1, 0);
        drv(0, 4'b1000, 4'b0000, 4'b0000, 2'd0, 0, 0);
        drv(1, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1, 0);
        drv(1, 4'b1000, 4'b1000, 4'b0000, 2'd3, 0, 0);
        drv(1, 4'b0000, 4'b0000, 4'b0000, 2'd3, 0, 0);
        // MAX_HOLD=1 instance
        cur_sel = 1'b1;
        drv(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
        drv(1, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1, 0);
        drv(1, 4'b0010, 4'b0000, 4'b0000, 2'd1, 0, 1);
        drv(1, 4'b0010, 4'b0000, 4'b0000, 2'd1, 0, 0);
        drv(1, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1, 0);
        drv(1, 4'b0010, 4'b0010, 4'b0000, 2'd1, 0, 0);
        drv(1, 4'b0000, 4'b0000, 4'b0000, 2'd1, 0, 0);
        drv(1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0);
        drv(1, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0, 0);
        drv(1, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0, 0);
        // drain with a bounded wait
        for (int k = 0; k < 5 && q_cyc.size() > 0; k++) @(posedge clk);
        #6;
        if (q_cyc.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q_cyc.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
